// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode constants, instruction field positions and
// the fetch-stage state encoding used by fetch_sequencer and pc_next_logic.
package cpu_isa_pkg;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;

    localparam logic [3:0] OPC_JC  = 4'hF;
    localparam logic [3:0] OPC_JMP = 4'hE;
    localparam logic [3:0] OPC_NOP = 4'h0;

    localparam logic [7:0] INSTR_NOP    = 8'h00;
    localparam logic [7:0] INSTR_UNPROG = 8'hFF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: JMP and taken JC load {imm, ra_value},
// everything else advances to pc+1 with modulo wrap.
module pc_next_logic #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    input  logic [3:0]        ra_value,
    input  logic              carry_flag,
    output logic [ADDR_W-1:0] next_pc
);
    import cpu_isa_pkg::*;

    logic [3:0]        opc_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] incr_s;

    assign opc_s    = instr[OPC_MSB:OPC_LSB];
    assign target_s = ADDR_W'({instr[3:0], ra_value});
    assign incr_s   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Branch resolution from the issued opcode and current flags
    always_comb begin
        next_pc = incr_s;
        case (opc_s)
            OPC_JMP: next_pc = target_s;
            OPC_JC: begin
                if (carry_flag) begin
                    next_pc = target_s;
                end else begin
                    next_pc = incr_s;
                end
            end
            default: next_pc = incr_s;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch stage: PC, instruction register and valid/ready issue.
// Optional `define FETCH_HALT_ON_FF_EN stops fetch on an unprogrammed (8'hFF) word.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [3:0]        ra_value,
    input  logic              carry_flag,
    input  logic              restart,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);
    import cpu_isa_pkg::*;

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] instr_r;
    logic [ADDR_W-1:0] instr_pc_r;
    logic              instr_valid_r;
    logic [ADDR_W-1:0] next_pc_s;

    // pc_r still addresses the issued instruction during ISSUE
    pc_next_logic #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_pc_next (
        .pc        (pc_r),
        .instr     (instr_r),
        .ra_value  (ra_value),
        .carry_flag(carry_flag),
        .next_pc   (next_pc_s)
    );

`ifdef FETCH_HALT_ON_FF_EN
    logic halted_r;

    // Fetch FSM with HALT on unprogrammed ROM words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            instr_r       <= DATA_W'(INSTR_NOP);
            instr_pc_r    <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else if (restart) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (rom_data == DATA_W'(INSTR_UNPROG)) begin
                        state_r       <= HALT;
                        instr_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                    end else begin
                        instr_r       <= rom_data;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        state_r       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_r <= 1'b0;
                        pc_r          <= next_pc_s;
                        state_r       <= FETCH;
                    end else begin
                        state_r       <= ISSUE;
                    end
                end
                HALT: begin
                    state_r       <= HALT;
                    instr_valid_r <= 1'b0;
                    halted_r      <= 1'b1;
                end
                default: begin
                    state_r       <= FETCH;
                    instr_valid_r <= 1'b0;
                    halted_r      <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_r;
`else
    // Fetch FSM: FETCH captures the ROM word, ISSUE waits for the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            instr_r       <= DATA_W'(INSTR_NOP);
            instr_pc_r    <= {ADDR_W{1'b0}};
            instr_valid_r <= 1'b0;
        end else if (restart) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            instr_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    instr_r       <= rom_data;
                    instr_pc_r    <= pc_r;
                    instr_valid_r <= 1'b1;
                    state_r       <= ISSUE;
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid_r <= 1'b0;
                        pc_r          <= next_pc_s;
                        state_r       <= FETCH;
                    end else begin
                        state_r       <= ISSUE;
                    end
                end
                default: begin
                    state_r       <= FETCH;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign halted = 1'b0;
`endif

    assign rom_addr    = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table of issued instructions with
// expected next PC, plus stall, restart, halt and async-reset sequences.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] ra_value;
    logic       carry_flag;
    logic       restart;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       halted;

    logic [7:0] rom [0:255];
    assign rom_data = rom[rom_addr];

    int n_total;
    int n_pass;

    fetch_sequencer #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .RESET_PC(8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ra_value   (ra_value),
        .carry_flag (carry_flag),
        .restart    (restart),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] op;
        logic [3:0] ra;
        logic       cy;
        logic [7:0] next_pc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!instr_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!instr_valid) begin
            n_total++;
            $display("FAIL %s: instr_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic handshake(input logic [3:0] ra, input logic cy);
        @(negedge clk);
        ra_value    = ra;
        carry_flag  = cy;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;

        vecs[0] = '{8'h00, 8'h22, 4'h0, 1'b0, 8'h01};
        vecs[1] = '{8'h01, 8'hE1, 4'h3, 1'b0, 8'h13};
        vecs[2] = '{8'h13, 8'hE1, 4'h6, 1'b0, 8'h16};
        vecs[3] = '{8'h16, 8'hF2, 4'h5, 1'b0, 8'h17};
        vecs[4] = '{8'h17, 8'hF2, 4'hF, 1'b1, 8'h2F};
        vecs[5] = '{8'h2F, 8'hEF, 4'hF, 1'b1, 8'hFF};
        vecs[6] = '{8'hFF, 8'h00, 4'h7, 1'b1, 8'h00};
        for (int i = 0; i < 7; i++) rom[vecs[i].pc] = vecs[i].op;

        rst_n       = 1'b0;
        restart     = 1'b0;
        instr_ready = 1'b0;
        ra_value    = 4'h0;
        carry_flag  = 1'b0;
        #12;
        chk("reset_rom_addr", rom_addr, 8'h00);
        chk("reset_instr", instr, 8'h00);
        chk("reset_instr_pc", instr_pc, 8'h00);
        chk("reset_valid", instr_valid, 1'b0);
        chk("reset_halted", halted, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_valid_latency", instr_valid, 1'b1);

        // Table: each entry is one issued instruction and the PC it leads to
        for (int i = 0; i < 7; i++) begin
            wait_valid($sformatf("vec%0d_wait", i));
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].op);
            chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].pc);
            handshake(vecs[i].ra, vecs[i].cy);
            chk($sformatf("vec%0d_next_pc", i), rom_addr, vecs[i].next_pc);
            chk($sformatf("vec%0d_valid_cleared", i), instr_valid, 1'b0);
        end

        // Stall: ready low for 5 cycles, then accept
        do_restart();
        chk("restart_pc", rom_addr, 8'h00);
        wait_valid("stall_wait");
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_instr", instr, 8'h22);
            chk("stall_instr_pc", instr_pc, 8'h00);
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_pc", rom_addr, 8'h00);
        end
        handshake(4'h0, 1'b0);
        chk("stall_release_pc", rom_addr, 8'h01);

        // Restart wins over a simultaneous handshake of JMP at 8'h2E
        rom[8'h00] = 8'hE2;
        rom[8'h2E] = 8'hE5;
        do_restart();
        wait_valid("rs_wait0");
        chk("rs_instr0", instr, 8'hE2);
        handshake(4'hE, 1'b0);
        chk("rs_jmp_pc", rom_addr, 8'h2E);
        wait_valid("rs_wait1");
        chk("rs_instr_pc", instr_pc, 8'h2E);
        @(negedge clk);
        restart     = 1'b1;
        instr_ready = 1'b1;
        ra_value    = 4'h1;
        @(posedge clk);
        #1;
        restart     = 1'b0;
        instr_ready = 1'b0;
        chk("rs_pc_reset", rom_addr, 8'h00);
        chk("rs_valid_dropped", instr_valid, 1'b0);
        wait_valid("rs_wait2");
        chk("rs_refetch_pc", instr_pc, 8'h00);

        // Unprogrammed word at 8'h35
        rom[8'h00] = 8'hE3;
        rom[8'h35] = 8'hFF;
        do_restart();
        wait_valid("ff_wait0");
        handshake(4'h5, 1'b0);
        chk("ff_jmp_pc", rom_addr, 8'h35);
`ifdef FETCH_HALT_ON_FF_EN
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_halted", halted, 1'b1);
            chk("halt_valid", instr_valid, 1'b0);
            chk("halt_pc", rom_addr, 8'h35);
        end
        do_restart();
        chk("halt_restart_pc", rom_addr, 8'h00);
        chk("halt_restart_halted", halted, 1'b0);
`else
        wait_valid("ff_wait1");
        chk("ff_instr", instr, 8'hFF);
        chk("ff_instr_pc", instr_pc, 8'h35);
        chk("ff_halted", halted, 1'b0);
        handshake(4'h0, 1'b1);
        chk("ff_jc_taken_pc", rom_addr, 8'hF0);
`endif

        // Async reset in the middle of ISSUE
        do_restart();
        wait_valid("ar_wait");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", instr_valid, 1'b0);
        chk("ar_instr", instr, 8'h00);
        chk("ar_pc", rom_addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
